load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Data-side initiator for the word-addressed unified memory's B port (memOp/addrB/dinB -> doutB/bValid/NOTready).
//  Takes one RV32I load/store from execute, issues word-aligned memory ops, extracts and extends loaded bytes/halves.
//  Merges sub-word stores by read-modify-write, since memory writes whole words only.
//  Returns one writeback response per request; single outstanding access.
// PARAMETERS
//  WAIT_LIMIT  16  max cycles in RD_WAIT without bValid before timeout error (4-bit counter, >=2)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; accept = req_valid & req_ready
//  req_store    in   1   1=store, 0=load
//  req_funct3   in   3   RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, low bits used for B/H
//  req_rd       in   5   load destination register
//  resp_valid   out  1   one-cycle pulse, no backpressure
//  resp_we      out  1   1 for successful load with rd!=0
//  resp_rd      out  5   destination echo
//  resp_rdata   out  32  extended load data, 0 for stores/errors
//  resp_err     out  1   access error (timeout, illegal funct3, misalign if enabled)
//  memOp        out  2   00 disable, 01 read-sext, 10 read-zext, 11 write
//  addrB        out  32  {addr[31:2],2'b00}
//  dinB         out  32  write word
//  doutB        in   32  read word, valid when bValid
//  bValid       in   1   read data valid (memory registers, 1 cycle after read op)
//  NOTready     in   1   memory stall: hold memOp/addrB/dinB, stay in state
// BEHAVIOUR
//  Reset: state IDLE, all resp_* 0, memOp 00, addrB/dinB 0, wait counter 0; abandons any access at once.
//  memOp/addrB/dinB decoded from registered state; memOp=00 in IDLE, RD_WAIT, RESP.
//  FSM: IDLE -accept-> RD (loads, B/H stores) or WR (SW); illegal funct3 -> RESP with err, no mem op.
//   RD: memOp=01 for B/H/W loads, 10 for BU/HU and RMW read; -> RD_WAIT unless NOTready.
//   RD_WAIT: counter++; bValid -> capture doutB; load -> RESP, sub-word store -> WR;
//            counter==WAIT_LIMIT-1 w/o bValid -> RESP with err, rdata 0.
//   WR: memOp=11, dinB = wdata (SW) or merged word; -> RESP unless NOTready.
//   RESP: resp_valid=1 one cycle -> IDLE; new request accepted next cycle earliest.
//  Latency (accept cycle = 0, NOTready low): load resp cycle 3; SW resp 2; SB/SH resp 4.
//  Load extract: lane=addr[1:0]; B/BU byte lane, H/HU half addr[1]; sign-ext B/H, zero-ext BU/HU/W.
//  Memory extension ignored; LSU alone extends.
//  Store merge: replace only the addressed byte/half of captured word; other bytes unchanged.
//  bValid outside RD_WAIT ignored. NOTready in RD delays issue; RD_WAIT counter does not run.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> RESP in 1 cycle,
//   resp_err=1, no memory op.
//  Undefined: misaligned address aligned down (H clears bit0, W clears [1:0]); access proceeds, no error.
// STRUCTURE
//  Package rv_mem_pkg: MEM_DISABLE/MEM_READ_SEXT/MEM_READ_ZEXT/MEM_WRITE, funct3 constants, FSM state encoding.
//  Sub-module lsu_lane_align (combinational): extract+extend for loads, byte/half merge for stores.
//  FSM, counter, request registers in top.
// TESTING (memory word 0x100 = 0x8081_8283)
//  LB 0x101 -> rdata 0xFFFF_FF82; LBU 0x101 -> 0x0000_0082; resp_valid cycle 3, resp_we=1.
//  LH 0x102 -> 0xFFFF_8081; LHU 0x102 -> 0x0000_8081; LW x0 -> resp_we=0.
//  SW 0x104 data 0xDEAD_BEEF -> one memOp=11 cycle, addrB 0x104, dinB 0xDEADBEEF, resp cycle 2; LW 0x104 -> same.
//  SB 0x103 data 0x55 -> read 0x100 then write dinB 0x5581_8283; resp cycle 4, resp_we=0.
//  NOTready high 3 cycles in RD -> memOp/addrB stable, resp at cycle 6; reset in RD_WAIT -> memOp 00 next cycle.
//  LW 0x102 -> macro: resp_err=1, memOp 00 throughout; no macro: reads 0x100, err=0. bValid held 0 -> err after WAIT_LIMIT.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared memory-op encodings, RV32I load/store funct3 values and LSU FSM states.
package rv_mem_pkg;

   typedef enum logic [1:0] {
      MEM_DISABLE   = 2'b00,
      MEM_READ_SEXT = 2'b01,
      MEM_READ_ZEXT = 2'b10,
      MEM_WRITE     = 2'b11
   } mem_op_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StWr,
      StResp
   } lsu_state_e;

   function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
      if (store) return funct3 inside {F3_B, F3_H, F3_W};
      return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
      unique case (funct3)
         F3_H, F3_HU: return lane[0];
         F3_W:        return lane != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response and memory B-port signals of the LSU.
// master is the LSU's view; slave is the execute stage plus memory.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_we;
   logic [4:0]  resp_rd;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  memOp;
   logic [31:0] addrB;
   logic [31:0] dinB;
   logic [31:0] doutB;
   logic        bValid;
   logic        NOTready;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
      input  doutB, bValid, NOTready,
      output req_ready, resp_valid, resp_we, resp_rd, resp_rdata, resp_err,
      output memOp, addrB, dinB
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
      output doutB, bValid, NOTready,
      input  req_ready, resp_valid, resp_we, resp_rd, resp_rdata, resp_err,
      input  memOp, addrB, dinB
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extract+extend loaded byte/half, merge sub-word store into a word.
module lsu_lane_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{lane_i, 3'b000} +: 8];
      // Halfword lane ignores bit 0, which aligns a misaligned half down.
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_o = {24'h0, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'h0, half_sel};
         default: load_data_o = word_i;
      endcase

      store_word_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            store_word_o = word_i;
            store_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         F3_H: begin
            store_word_o = word_i;
            store_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: store_word_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving the word-addressed memory B port; one access outstanding.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W requests error out instead of aligning down.
module load_store_unit
   import rv_mem_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input logic               clk,
   input logic               reset,
   load_store_unit_if.master bus
);

   localparam logic [3:0] LastCnt = 4'(WAIT_LIMIT - 1);

   lsu_state_e  state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        trap;
   logic [31:0] load_data;
   logic [31:0] store_word;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   lsu_lane_align u_lane_align (
      .funct3_i     (f3_q),
      .lane_i       (addr_q[1:0]),
      .word_i       (data_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_word_o (store_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         store_q <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rd_q    <= 5'd0;
         data_q  <= 32'h0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      store_d = store_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = 4'd0;
            if (bus.req_valid) begin
               store_d = bus.req_store;
               f3_d    = bus.req_funct3;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rd_d    = bus.req_rd;
               data_d  = 32'h0;
               err_d   = 1'b0;
               if (!f3_legal(bus.req_store, bus.req_funct3) || trap) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else if (bus.req_store && bus.req_funct3 == F3_W) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            if (!bus.NOTready) state_d = StRdWait;
         end
         StRdWait: begin
            cnt_d = cnt_q + 4'd1;
            if (bus.bValid) begin
               data_d  = bus.doutB;
               state_d = store_q ? StWr : StResp;
            end else if (cnt_q == LastCnt) begin
               err_d   = 1'b1;
               data_d  = 32'h0;
               state_d = StResp;
            end
         end
         StWr: begin
            if (!bus.NOTready) state_d = StResp;
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state_q == StIdle);
      bus.memOp      = MEM_DISABLE;
      bus.addrB      = 32'h0;
      bus.dinB       = 32'h0;
      bus.resp_valid = 1'b0;
      bus.resp_we    = 1'b0;
      bus.resp_rd    = 5'd0;
      bus.resp_rdata = 32'h0;
      bus.resp_err   = 1'b0;

      unique case (state_q)
         StRd: begin
            // RMW reads zero-extend; extension is redone here anyway.
            bus.memOp = (store_q || f3_q == F3_BU || f3_q == F3_HU) ? MEM_READ_ZEXT
                                                                     : MEM_READ_SEXT;
            bus.addrB = {addr_q[31:2], 2'b00};
         end
         StWr: begin
            bus.memOp = MEM_WRITE;
            bus.addrB = {addr_q[31:2], 2'b00};
            bus.dinB  = store_word;
         end
         StResp: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rd    = rd_q;
            bus.resp_we    = !err_q && !store_q && (rd_q != 5'd0);
            bus.resp_rdata = (!err_q && !store_q) ? load_data : 32'h0;
         end
         default: ;
      endcase
   end

endmodule
